instqueue: RTL and testbench

- Circular instruction FIFO between instruction fetch and decoder.
- Buffers fetched instruction words with their PCs and pops one entry per cycle into registered decoder outputs.
- Throttles fetch via an almost-full flag.
- Flushes entirely on a pipeline clear (branch mispredict or jump redirect).

---
 rtl/instqueue_if.sv | 34 +++
 rtl/instqueue.sv | 99 +++++++++
 tb/tb_instqueue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/instqueue_if.sv
// instqueue_if: fetch/decode handshake bundle for the instruction queue.
//   slave  modport - the queue itself: takes pushes from fetch and the
//                    downstream stall, drives almost-full and decoder outputs.
//   master modport - the environment around the queue (fetch + decode side).
// Parameters: IDWidth (instruction width), AddressWidth (PC width).
interface instqueue_if #(
    parameter int unsigned IDWidth      = 32,
    parameter int unsigned AddressWidth = 32
) ();
    logic                    if_instqueue_en_in;
    logic [IDWidth-1:0]      if_instqueue_inst_in;
    logic [AddressWidth-1:0] if_instqueue_pc_in;
    logic                    instqueue_if_full_out;
    logic                    rs_instqueue_stall_in;
    logic                    instqueue_decoder_en_out;
    logic [IDWidth-1:0]      instqueue_decoder_inst_out;
    logic [AddressWidth-1:0] instqueue_decoder_pc_out;

    modport slave (
        input  if_instqueue_en_in, if_instqueue_inst_in, if_instqueue_pc_in,
        input  rs_instqueue_stall_in,
        output instqueue_if_full_out,
        output instqueue_decoder_en_out, instqueue_decoder_inst_out,
        output instqueue_decoder_pc_out
    );

    modport master (
        output if_instqueue_en_in, if_instqueue_inst_in, if_instqueue_pc_in,
        output rs_instqueue_stall_in,
        input  instqueue_if_full_out,
        input  instqueue_decoder_en_out, instqueue_decoder_inst_out,
        input  instqueue_decoder_pc_out
    );
endinterface

// File: rtl/instqueue.sv
// instqueue: circular instruction FIFO between fetch and decode.
// Buffers {inst, pc} pairs, pops at most one per cycle into registered
// decoder outputs, raises an almost-full flag to throttle fetch and is
// flushed completely by clear_in.
// Ports:
//   clk_in   - clock
//   rst_in   - asynchronous active-low reset
//   rdy_in   - global ready; low freezes every register
//   clear_in - flush (mispredict / redirect); wins over push and pop
//   bus      - instqueue_if.slave: fetch push, almost-full, downstream
//              stall, decoder en/inst/pc
// Optional build macro: INSTQUEUE_BYPASS_EN - when the queue is empty and
// downstream is not stalled, a pushed word goes straight to the decoder
// outputs on the same edge without touching storage.
module instqueue #(
    parameter int unsigned IDWidth      = 32,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned FULL_MARGIN  = 2
) (
    input logic         clk_in,
    input logic         rst_in,
    input logic         rdy_in,
    input logic         clear_in,
    instqueue_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] CntFull = (PtrW+1)'(DEPTH);
    localparam logic [PtrW:0] CntThr  = (PtrW+1)'(DEPTH - FULL_MARGIN);

    logic [IDWidth-1:0]      inst_mem [DEPTH];
    logic [AddressWidth-1:0] pc_mem   [DEPTH];
    logic [PtrW-1:0]         head, tail;
    logic [PtrW:0]           count, count_nxt;
    logic                    do_pop, do_push, do_bypass;

    always_comb begin
        do_pop = (count != '0) && !bus.rs_instqueue_stall_in;
`ifdef INSTQUEUE_BYPASS_EN
        do_bypass = (count == '0) && bus.if_instqueue_en_in && !bus.rs_instqueue_stall_in;
`else
        do_bypass = 1'b0;
`endif
        // A full queue still accepts a push when the same edge frees a slot.
        do_push = bus.if_instqueue_en_in && !do_bypass && ((count != CntFull) || do_pop);
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + (PtrW+1)'(1);
        else if (do_pop && !do_push)
            count_nxt = count - (PtrW+1)'(1);
    end

    // Storage has no reset; only entries between head and tail are meaningful.
    // With count==DEPTH and push+pop, tail==head: the pop below reads the old
    // word before this write lands.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear_in && do_push) begin
            inst_mem[tail] <= bus.if_instqueue_inst_in;
            pc_mem[tail]   <= bus.if_instqueue_pc_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head                           <= '0;
            tail                           <= '0;
            count                          <= '0;
            bus.instqueue_if_full_out      <= 1'b0;
            bus.instqueue_decoder_en_out   <= 1'b0;
            bus.instqueue_decoder_inst_out <= '0;
            bus.instqueue_decoder_pc_out   <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                head                         <= '0;
                tail                         <= '0;
                count                        <= '0;
                bus.instqueue_if_full_out    <= 1'b0;
                bus.instqueue_decoder_en_out <= 1'b0;
            end else begin
                if (do_pop) begin
                    bus.instqueue_decoder_inst_out <= inst_mem[head];
                    bus.instqueue_decoder_pc_out   <= pc_mem[head];
                    bus.instqueue_decoder_en_out   <= 1'b1;
                    head                           <= head + 1'b1;
                end else if (do_bypass) begin
                    bus.instqueue_decoder_inst_out <= bus.if_instqueue_inst_in;
                    bus.instqueue_decoder_pc_out   <= bus.if_instqueue_pc_in;
                    bus.instqueue_decoder_en_out   <= 1'b1;
                end else begin
                    bus.instqueue_decoder_en_out   <= 1'b0;
                end
                if (do_push)
                    tail <= tail + 1'b1;
                count                     <= count_nxt;
                bus.instqueue_if_full_out <= (count_nxt >= CntThr);
            end
        end
    end
endmodule

// File: tb/tb_instqueue.sv
// tb_instqueue: directed self-checking bench for instqueue (DEPTH 16,
// FULL_MARGIN 2). A queue of expected {inst, pc} pairs is filled as words
// are pushed and consumed whenever the decoder output is valid.
module tb_instqueue;
    logic clk_in   = 1'b0;
    logic rst_in   = 1'b1;
    logic rdy_in   = 1'b1;
    logic clear_in = 1'b0;

    int tests = 0;
    int fails = 0;
    int emitted = 0;
    logic [31:0] exp_inst[$];
    logic [31:0] exp_pc[$];

    instqueue_if #(.IDWidth(32), .AddressWidth(32)) bus ();

    instqueue #(
        .IDWidth(32), .AddressWidth(32), .DEPTH(16), .FULL_MARGIN(2)
    ) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rdy_in  (rdy_in),
        .clear_in(clear_in),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic en, input logic [31:0] inst, input logic [31:0] pc,
                         input logic stall);
        bus.if_instqueue_en_in    = en;
        bus.if_instqueue_inst_in  = inst;
        bus.if_instqueue_pc_in    = pc;
        bus.rs_instqueue_stall_in = stall;
    endtask

    task automatic expect_word(input logic [31:0] inst, input logic [31:0] pc);
        exp_inst.push_back(inst);
        exp_pc.push_back(pc);
    endtask

    task automatic sample();
        if (bus.instqueue_decoder_en_out === 1'b1) begin
            if (exp_pc.size() == 0) begin
                check("spurious_en", {63'd0, bus.instqueue_decoder_en_out}, 64'd0);
            end else begin
                check("out_pc", {32'd0, bus.instqueue_decoder_pc_out}, {32'd0, exp_pc.pop_front()});
                check("out_inst", {32'd0, bus.instqueue_decoder_inst_out}, {32'd0, exp_inst.pop_front()});
                emitted++;
            end
        end
    endtask

    task automatic drain(input int budget);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        for (int c = 0; c < budget && exp_pc.size() > 0; c++) begin
            step();
            sample();
        end
        check("drain_left", 64'(exp_pc.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        #1 rst_in = 1'b0;
        #1;
        check("rst_en",   {63'd0, bus.instqueue_decoder_en_out}, 64'd0);
        check("rst_inst", {32'd0, bus.instqueue_decoder_inst_out}, 64'd0);
        check("rst_pc",   {32'd0, bus.instqueue_decoder_pc_out}, 64'd0);
        check("rst_full", {63'd0, bus.instqueue_if_full_out}, 64'd0);
        check("rst_cnt",  64'(dut.count), 64'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;

        // First-word latency
        drive(1'b1, 32'h0000_0013, 32'h0, 1'b0);
        step();
`ifdef INSTQUEUE_BYPASS_EN
        check("lat_e1_en",   {63'd0, bus.instqueue_decoder_en_out}, 64'd1);
        check("lat_e1_inst", {32'd0, bus.instqueue_decoder_inst_out}, 64'h13);
`else
        check("lat_e1_en",   {63'd0, bus.instqueue_decoder_en_out}, 64'd0);
`endif
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        step();
`ifdef INSTQUEUE_BYPASS_EN
        check("lat_e2_en",   {63'd0, bus.instqueue_decoder_en_out}, 64'd0);
`else
        check("lat_e2_en",   {63'd0, bus.instqueue_decoder_en_out}, 64'd1);
        check("lat_e2_inst", {32'd0, bus.instqueue_decoder_inst_out}, 64'h13);
        check("lat_e2_pc",   {32'd0, bus.instqueue_decoder_pc_out}, 64'h0);
`endif

        // Fill under stall, almost-full threshold, overflow drop, ordered drain
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h1000 + i, 32'(4 * i), 1'b1);
            expect_word(32'h1000 + i, 32'(4 * i));
            step();
            if (i == 12) check("full_at13", {63'd0, bus.instqueue_if_full_out}, 64'd0);
            if (i == 13) check("full_at14", {63'd0, bus.instqueue_if_full_out}, 64'd1);
        end
        check("fill_cnt16", 64'(dut.count), 64'd16);
        drive(1'b1, 32'hDEAD, 32'h40, 1'b1);
        step();
        check("drop_cnt", 64'(dut.count), 64'd16);
        check("drop_en",  {63'd0, bus.instqueue_decoder_en_out}, 64'd0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            step();
            check("drain_en", {63'd0, bus.instqueue_decoder_en_out}, 64'd1);
            sample();
            if (j == 2) check("full_pop2", {63'd0, bus.instqueue_if_full_out}, 64'd1);
            if (j == 3) check("full_pop3", {63'd0, bus.instqueue_if_full_out}, 64'd0);
        end
        check("drain_left", 64'(exp_pc.size()), 64'd0);
        step();
        check("after_en",   {63'd0, bus.instqueue_decoder_en_out}, 64'd0);
        check("after_pc",   {32'd0, bus.instqueue_decoder_pc_out}, 64'h3C);
        check("after_inst", {32'd0, bus.instqueue_decoder_inst_out}, 64'h100F);

        // Push and pop on the same edge while full
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h3000 + i, 32'h200 + 32'(4 * i), 1'b1);
            expect_word(32'h3000 + i, 32'h200 + 32'(4 * i));
            step();
        end
        check("pp_cnt_before", 64'(dut.count), 64'd16);
        drive(1'b1, 32'h3010, 32'h240, 1'b0);
        expect_word(32'h3010, 32'h240);
        step();
        check("pp_en", {63'd0, bus.instqueue_decoder_en_out}, 64'd1);
        sample();
        check("pp_cnt_after", 64'(dut.count), 64'd16);
        drain(20);

        // Continuous stream, pointers wrap
        emitted = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 32'h2000 + i, 32'(4 * i), 1'b0);
            expect_word(32'h2000 + i, 32'(4 * i));
            step();
            sample();
            check("stream_cnt_le1", {63'd0, (dut.count <= 5'd1)}, 64'd1);
        end
        drain(5);
        check("stream_emitted", 64'(emitted), 64'd40);

        // Clear with a simultaneous push
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h5000 + i, 32'h400 + 32'(4 * i), 1'b1);
            step();
        end
        check("clr_cnt5", 64'(dut.count), 64'd5);
        clear_in = 1'b1;
        drive(1'b1, 32'h5999, 32'h999, 1'b0);
        step();
        clear_in = 1'b0;
        check("clr_cnt",  64'(dut.count), 64'd0);
        check("clr_en",   {63'd0, bus.instqueue_decoder_en_out}, 64'd0);
        check("clr_full", {63'd0, bus.instqueue_if_full_out}, 64'd0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        step();
        check("clr_no_emit", {63'd0, bus.instqueue_decoder_en_out}, 64'd0);
        drive(1'b1, 32'h5ABC, 32'h500, 1'b0);
        expect_word(32'h5ABC, 32'h500);
        step();
        sample();
        drain(5);

        // rdy_in low freezes state while push/stall toggle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h6000 + i, 32'h600 + 32'(4 * i), 1'b1);
            expect_word(32'h6000 + i, 32'h600 + 32'(4 * i));
            step();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        step();
        check("rdy_pre_en", {63'd0, bus.instqueue_decoder_en_out}, 64'd1);
        sample();
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive((k % 2) == 0, 32'h6F00 + k, 32'h6F0 + 32'(4 * k), (k % 2) == 1);
            step();
            check("frz_en",   {63'd0, bus.instqueue_decoder_en_out}, 64'd1);
            check("frz_pc",   {32'd0, bus.instqueue_decoder_pc_out}, 64'h600);
            check("frz_inst", {32'd0, bus.instqueue_decoder_inst_out}, 64'h6000);
            check("frz_cnt",  64'(dut.count), 64'd2);
        end
        rdy_in = 1'b1;
        drain(10);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h7000 + i, 32'h700 + 32'(4 * i), 1'b1);
            step();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        step();
        check("ares_pre_en", {63'd0, bus.instqueue_decoder_en_out}, 64'd1);
        #2 rst_in = 1'b0;
        #1;
        check("ares_en",   {63'd0, bus.instqueue_decoder_en_out}, 64'd0);
        check("ares_inst", {32'd0, bus.instqueue_decoder_inst_out}, 64'd0);
        check("ares_pc",   {32'd0, bus.instqueue_decoder_pc_out}, 64'd0);
        check("ares_full", {63'd0, bus.instqueue_if_full_out}, 64'd0);
        check("ares_cnt",  64'(dut.count), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        step();
        check("ares_post_en", {63'd0, bus.instqueue_decoder_en_out}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
